// File: rtl/harmonic_pkg.sv
// Shared widths and FSM state encoding for the harmonic-sum datapath and its
// result formatter.
package harmonic_pkg;

    localparam int SUM_W      = 20;
    localparam int INT_W      = 4;
    localparam int FRAC_W     = 16;
    localparam int BCD_DIGITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } fmt_state_e;

endpackage

// File: rtl/frac_digit_step.sv
// One step of binary-fraction to decimal conversion: multiply by ten and split
// off the integer digit from the remaining fraction.
module frac_digit_step
    import harmonic_pkg::*;
(
    input  logic [FRAC_W-1:0] frac_i,
    output logic [3:0]        digit_o,
    output logic [FRAC_W-1:0] rem_o
);

    logic [FRAC_W+3:0] frac_ext;
    logic [FRAC_W+3:0] prod;

    // x*10 = x*8 + x*2; frac < 1 so the product always fits in 20 bits.
    assign frac_ext = {4'b0000, frac_i};
    assign prod     = (frac_ext << 3) + (frac_ext << 1);
    assign digit_o  = prod[FRAC_W+3:FRAC_W];
    assign rem_o    = prod[FRAC_W-1:0];

endmodule

// File: rtl/harmonic_result_formatter.sv
// Converts an unsigned 4.16 harmonic sum into two integer BCD digits and up to
// four truncated fraction BCD digits, one fraction digit per clock.
module harmonic_result_formatter
    import harmonic_pkg::*;
#(
    parameter int FRAC_DIGITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       int_bcd,
    output logic [15:0]      frac_bcd
);

    localparam logic [1:0] LAST_CNT = 2'(FRAC_DIGITS - 1);

    fmt_state_e        state_q, state_d;
    logic [FRAC_W-1:0] frac_q, frac_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [7:0]        int_bcd_q, int_bcd_d;
    logic [15:0]       frac_bcd_q, frac_bcd_d;

    logic [3:0]        step_digit;
    logic [FRAC_W-1:0] step_rem;

    function automatic logic [7:0] int_to_bcd(input logic [INT_W-1:0] i);
        if (i >= 4'd10)
            return {4'd1, 4'(i - 4'd10)};
        else
            return {4'd0, i};
    endfunction

    // Slot 0 is the most significant digit after the decimal point.
    function automatic logic [15:0] set_slot(input logic [15:0] cur,
                                             input logic [1:0]  slot,
                                             input logic [3:0]  digit);
        logic [15:0] r;
        r = cur;
        case (slot)
            2'd0:    r[15:12] = digit;
            2'd1:    r[11:8]  = digit;
            2'd2:    r[7:4]   = digit;
            default: r[3:0]   = digit;
        endcase
        return r;
    endfunction

    frac_digit_step u_step (
        .frac_i  (frac_q),
        .digit_o (step_digit),
        .rem_o   (step_rem)
    );

    always_comb begin
        state_d    = state_q;
        frac_d     = frac_q;
        cnt_d      = cnt_q;
        int_bcd_d  = int_bcd_q;
        frac_bcd_d = frac_bcd_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    frac_d     = in_sum[FRAC_W-1:0];
                    int_bcd_d  = int_to_bcd(in_sum[SUM_W-1:FRAC_W]);
                    frac_bcd_d = '0;
                    cnt_d      = '0;
                    state_d    = ST_CONV;
                end
            end
            ST_CONV: begin
                frac_d     = step_rem;
                frac_bcd_d = set_slot(frac_bcd_q, cnt_q, step_digit);
                cnt_d      = cnt_q + 2'd1;
                if (cnt_q == LAST_CNT)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            frac_q     <= '0;
            cnt_q      <= '0;
            int_bcd_q  <= '0;
            frac_bcd_q <= '0;
        end else begin
            state_q    <= state_d;
            frac_q     <= frac_d;
            cnt_q      <= cnt_d;
            int_bcd_q  <= int_bcd_d;
            frac_bcd_q <= frac_bcd_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign int_bcd   = int_bcd_q;
    assign frac_bcd  = frac_bcd_q;

endmodule

// File: tb/tb_harmonic_result_formatter.sv
// Directed-vector bench for harmonic_result_formatter with 4- and 2-digit builds.
module tb_harmonic_result_formatter;

    logic        clk = 1'b0;
    logic        rst;
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;

    logic        iv, ir, ov, ordy;
    logic [19:0] isum;
    logic [7:0]  ib;
    logic [15:0] fb;

    logic        iv2, ir2, ov2, ordy2;
    logic [19:0] isum2;
    logic [7:0]  ib2;
    logic [15:0] fb2;

    typedef struct {
        logic [19:0] sum;
        logic [7:0]  ib;
        logic [15:0] fb;
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    harmonic_result_formatter #(.FRAC_DIGITS(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .in_sum(isum),
        .out_valid(ov), .out_ready(ordy), .int_bcd(ib), .frac_bcd(fb)
    );

    harmonic_result_formatter #(.FRAC_DIGITS(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_sum(isum2),
        .out_valid(ov2), .out_ready(ordy2), .int_bcd(ib2), .frac_bcd(fb2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run4(input logic [19:0] s, input logic [7:0] eib, input logic [15:0] efb,
                        input string tag);
        int n;
        n = 0;
        while (!ir && n < 20) begin @(posedge clk); #1; n++; end
        check({tag, " ready"}, 32'(ir), 32'd1);
        iv = 1'b1; isum = s;
        @(posedge clk); #1;
        iv = 1'b0;
        check({tag, " accepted"}, 32'(ir), 32'd0);
        n = 0;
        while (!ov && n < 20) begin @(posedge clk); #1; n++; end
        check({tag, " latency"}, 32'(n), 32'd4);
        check({tag, " int"}, 32'(ib), 32'(eib));
        check({tag, " frac"}, 32'(fb), 32'(efb));
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
        check({tag, " release"}, {30'd0, ov, ir}, 32'b01);
        check({tag, " retain"}, {ib, fb}, {eib, efb});
    endtask

    task automatic run2(input logic [19:0] s, input logic [7:0] eib, input logic [15:0] efb,
                        input string tag);
        int n;
        n = 0;
        while (!ir2 && n < 20) begin @(posedge clk); #1; n++; end
        iv2 = 1'b1; isum2 = s;
        @(posedge clk); #1;
        iv2 = 1'b0;
        n = 0;
        while (!ov2 && n < 20) begin @(posedge clk); #1; n++; end
        check({tag, " latency"}, 32'(n), 32'd2);
        check({tag, " int"}, 32'(ib2), 32'(eib));
        check({tag, " frac"}, 32'(fb2), 32'(efb));
        ordy2 = 1'b1;
        @(posedge clk); #1;
        ordy2 = 1'b0;
        check({tag, " release"}, {30'd0, ov2, ir2}, 32'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n, seen, prev;
        logic [19:0] bsum[4];
        logic [7:0]  bib[3];
        logic [15:0] bfb[3];

        tbl[0] = '{20'h10000, 8'h01, 16'h0000};
        tbl[1] = '{20'h1D554, 8'h01, 16'h8333};
        tbl[2] = '{20'h0FFFF, 8'h00, 16'h9999};
        tbl[3] = '{20'hFFFFF, 8'h15, 16'h9999};
        tbl[4] = '{20'h34000, 8'h03, 16'h2500};
        tbl[5] = '{20'hC1999, 8'h12, 16'h0999};
        tbl[6] = '{20'h90001, 8'h09, 16'h0000};
        tbl[7] = '{20'h0A000, 8'h00, 16'h6250};

        rst = 1'b1;
        iv = 0; ordy = 0; isum = '0;
        iv2 = 0; ordy2 = 0; isum2 = '0;
        #1 rst = 1'b0;
        #2;
        check("reset dut4", {ir, ov, ib, fb}, {1'b1, 1'b0, 8'h00, 16'h0000});
        check("reset dut2", {ir2, ov2, ib2, fb2}, {1'b1, 1'b0, 8'h00, 16'h0000});
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;

        // Table vectors; the first one is accepted on the first edge after reset.
        for (int i = 0; i < 8; i++)
            run4(tbl[i].sum, tbl[i].ib, tbl[i].fb, $sformatf("vec%0d", i));

        // Two-digit build: only slots 0 and 1 are ever written.
        run2(20'h18000, 8'h01, 16'h5000, "d2 1.5");
        run2(20'h1D554, 8'h01, 16'h8300, "d2 h3");
        run2(20'hFFFFF, 8'h15, 16'h9900, "d2 max");

        // Asynchronous reset part-way through conversion.
        iv = 1'b1; isum = 20'hFFFFF;
        @(posedge clk); #1;
        iv = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midconv digits", 32'(fb), 32'h9900);
        #2 rst = 1'b0;
        #1;
        check("async reset", {ir, ov, ib, fb}, {1'b1, 1'b0, 8'h00, 16'h0000});
        rst = 1'b1;
        seen = 0;
        repeat (8) begin @(posedge clk); #1; if (ov) seen = 1; end
        check("no valid after abort", 32'(seen), 32'd0);
        run4(20'h1D554, 8'h01, 16'h8333, "post reset");

        // Backpressure with a new sum already waiting.
        iv = 1'b1; isum = 20'hA0000;
        @(posedge clk); #1;
        isum = 20'h34000;
        n = 0;
        while (!ov && n < 20) begin @(posedge clk); #1; n++; end
        check("bp result", {ov, ib, fb}, {1'b1, 8'h10, 16'h0000});
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp hold%0d", k), {ov, ir, ib, fb}, {1'b1, 1'b0, 8'h10, 16'h0000});
        end
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
        check("bp transfer", {30'd0, ov, ir}, 32'b01);
        @(posedge clk); #1;
        iv = 1'b0;
        check("bp next accepted", 32'(ir), 32'd0);
        n = 0;
        while (!ov && n < 20) begin @(posedge clk); #1; n++; end
        check("bp next latency", 32'(n), 32'd4);
        check("bp next result", {ib, fb}, {8'h03, 16'h2500});
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;

        // Back-to-back streaming.
        bsum[0] = 20'h1D554; bib[0] = 8'h01; bfb[0] = 16'h8333;
        bsum[1] = 20'h0FFFF; bib[1] = 8'h00; bfb[1] = 16'h9999;
        bsum[2] = 20'hC1999; bib[2] = 8'h12; bfb[2] = 16'h0999;
        bsum[3] = 20'h00000;
        prev = 0;
        ordy = 1'b1; iv = 1'b1; isum = bsum[0];
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!ov && n < 20) begin @(posedge clk); #1; n++; end
            check($sformatf("b2b%0d result", k), {ov, ib, fb}, {1'b1, bib[k], bfb[k]});
            if (k > 0)
                check($sformatf("b2b%0d period", k), 32'(cyc - prev), 32'd6);
            prev = cyc;
            isum = bsum[k+1];
            if (k == 2) iv = 1'b0;
            @(posedge clk); #1;
        end
        ordy = 1'b0;
        check("b2b end idle", {30'd0, ov, ir}, 32'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
